// File: rtl/masked_sbox_stream_pkg.sv
// Shared constants and helpers for the masked S-box stream block.
// Contents:
//   blind_nrnd      number of blinding bits per S-box stage for a share count
//   rndz_per_lane   DOM Z randomness bits per lane (11*S*(S-1))
//   rndb_per_lane   blinding randomness bits per lane (18*blind_nrnd(S))
//   fifo_depth      output FIFO depth / credit limit (SBOX_LAT+2)
//   gf_mul, gf_inv  GF(2^8) arithmetic, AES polynomial x^8+x^4+x^3+x+1
//   sbox_raw        AES S-box without the 8'h63 constant (inverse + linear map)
package masked_sbox_stream_pkg;

  function automatic int blind_nrnd(input int shares);
    return (shares * (shares - 1)) / 2;
  endfunction

  function automatic int rndz_per_lane(input int shares);
    return 11 * shares * (shares - 1);
  endfunction

  function automatic int rndb_per_lane(input int shares);
    return 18 * blind_nrnd(shares);
  endfunction

  function automatic int fifo_depth(input int sbox_lat);
    return sbox_lat + 2;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  // x^254 == x^-1 for x != 0, and maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_raw(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Functional model of one masked AES S-box lane with the DOM interface and a
// fixed register latency. Output shares 1..S-1 are fresh masks folded from the
// lane randomness; share 0 carries the raw S-box (no 8'h63) XOR those masks.
// The gate-level DOM netlist drops in behind the same ports and latency.
// Ports:
//   ClkxCI  in  clock
//   RstxBI  in  async active-low reset, clears the pipe
//   XxDI    in  8*SHARES  input shares, share s at [s*8 +: 8]
//   ZxDI    in  DOM Z randomness for this lane
//   BtxDI   in  blinding randomness for this lane
//   QxDO    out 8*SHARES  output shares, SBOX_LAT cycles after XxDI
module aes_sbox
  import masked_sbox_stream_pkg::*;
#(
  parameter int SHARES   = 2,
  parameter int SBOX_LAT = 4
) (
  input  logic                                ClkxCI,
  input  logic                                RstxBI,
  input  logic [8*SHARES-1:0]                 XxDI,
  input  logic [rndz_per_lane(SHARES)-1:0]    ZxDI,
  input  logic [rndb_per_lane(SHARES)-1:0]    BtxDI,
  output logic [8*SHARES-1:0]                 QxDO
);
  localparam int RZ = rndz_per_lane(SHARES);
  localparam int RB = rndb_per_lane(SHARES);
  localparam int MW = 8 * (SHARES - 1);

  logic [MW-1:0]       mask;
  logic [7:0]          value;
  logic [7:0]          share0;
  logic [8*SHARES-1:0] q_next;
  logic [8*SHARES-1:0] pipe [SBOX_LAT];

  // Every randomness bit lands in some mask byte, round-robin over the bytes.
  always_comb begin
    mask = '0;
    for (int i = 0; i < RZ; i++)
      mask[((i / 8) % (SHARES - 1)) * 8 + (i % 8)] = mask[((i / 8) % (SHARES - 1)) * 8 + (i % 8)] ^ ZxDI[i];
    for (int i = 0; i < RB; i++)
      mask[(((RZ + i) / 8) % (SHARES - 1)) * 8 + ((RZ + i) % 8)] =
        mask[(((RZ + i) / 8) % (SHARES - 1)) * 8 + ((RZ + i) % 8)] ^ BtxDI[i];
  end

  always_comb begin
    value = 8'h00;
    for (int s = 0; s < SHARES; s++) value = value ^ XxDI[s*8 +: 8];
    share0 = sbox_raw(value);
    q_next = '0;
    for (int s = 1; s < SHARES; s++) begin
      q_next[s*8 +: 8] = mask[(s-1)*8 +: 8];
      share0           = share0 ^ mask[(s-1)*8 +: 8];
    end
    q_next[7:0] = share0;
  end

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      for (int i = 0; i < SBOX_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= q_next;
      for (int i = 1; i < SBOX_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign QxDO = pipe[SBOX_LAT-1];

endmodule

// File: rtl/sbox_stream_fifo.sv
// Small register FIFO with a count output. Pointers wrap modulo DEPTH, so DEPTH
// need not be a power of two. The caller guarantees no push when full and no
// pop when empty (the stream block enforces this with its credit counter).
// Ports:
//   clk, rst_n   clock, async active-low reset (clears storage, pointers, count)
//   push, wdata  write one entry
//   pop          drop the head entry
//   head         current head entry
//   cnt          number of stored entries
module sbox_stream_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] cnt
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/masked_sbox_stream.sv
// Streaming front-end for LANES parallel masked AES S-boxes. Adds a valid/ready
// input, a sideband tag, a credit-counted output FIFO and a randomness guard.
// Optional build macro: SBOX_AFFINE_EN -- XOR 8'h63 into share 0 of every lane
// at the FIFO push so the output is a full SubBytes; otherwise the raw S-box
// output is passed through. Latency is the same either way.
//
// Handshake: a beat moves on a side when valid and ready are both high at the
// rising clock edge; ready never depends on the same side's valid. Input side
// additionally requires RndValidxSI. InReadyxSO comes only from registers.
//
// Ports:
//   ClkxCI, RstxBI  clock, async active-low reset
//   InValidxSI/InReadyxSO/InDataxDI/InTagxDI  input beat (lane l share s at (l*SHARES+s)*8)
//   RndValidxSI     randomness valid this cycle
//   RandomZxDI      DOM Z randomness, RZ bits per lane
//   RandomBxDI      blinding randomness, RB bits per lane
//   OutValidxSO/OutReadyxSI/OutDataxDO/OutTagxDO  output beat, same packing
//   RndErrxSO       sticky: randomness missing while beats were in the pipe
module masked_sbox_stream
  import masked_sbox_stream_pkg::*;
#(
  parameter int SHARES   = 2,
  parameter int LANES    = 4,
  parameter int SBOX_LAT = 4,
  parameter int TAG_W    = 4
) (
  input  logic                                     ClkxCI,
  input  logic                                     RstxBI,
  input  logic                                     InValidxSI,
  output logic                                     InReadyxSO,
  input  logic [8*SHARES*LANES-1:0]                InDataxDI,
  input  logic [TAG_W-1:0]                         InTagxDI,
  input  logic                                     RndValidxSI,
  input  logic [LANES*rndz_per_lane(SHARES)-1:0]   RandomZxDI,
  input  logic [LANES*rndb_per_lane(SHARES)-1:0]   RandomBxDI,
  output logic                                     OutValidxSO,
  input  logic                                     OutReadyxSI,
  output logic [8*SHARES*LANES-1:0]                OutDataxDO,
  output logic [TAG_W-1:0]                         OutTagxDO,
  output logic                                     RndErrxSO
);
  localparam int RZ    = rndz_per_lane(SHARES);
  localparam int RB    = rndb_per_lane(SHARES);
  localparam int DEPTH = fifo_depth(SBOX_LAT);
  localparam int DW    = 8 * SHARES * LANES;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             running;
  logic             accept;
  logic             push;
  logic             pop;
  logic [DW-1:0]    sbox_in;
  logic [DW-1:0]    sbox_hold;
  logic [DW-1:0]    sbox_out;
  logic [DW-1:0]    push_data;
  logic [SBOX_LAT-1:0] vld_pipe;
  logic [TAG_W-1:0] tag_pipe [SBOX_LAT];
  logic [CW-1:0]    outstanding;
  logic [CW-1:0]    inflight;
  logic [CW-1:0]    fifo_cnt;

  // Credits cover both the S-box pipe and the FIFO, so every accepted beat
  // already owns a FIFO slot and the free-running pipe can never overflow it.
  assign InReadyxSO  = running && (outstanding < CW'(DEPTH));
  assign accept      = InValidxSI && InReadyxSO && RndValidxSI;
  assign OutValidxSO = (fifo_cnt != '0);
  assign pop         = OutValidxSO && OutReadyxSI;
  assign push        = vld_pipe[SBOX_LAT-1];

  // Bubbles keep the S-box inputs at their last accepted value.
  assign sbox_in = accept ? InDataxDI : sbox_hold;

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      running     <= 1'b0;
      sbox_hold   <= '0;
      vld_pipe    <= '0;
      for (int i = 0; i < SBOX_LAT; i++) tag_pipe[i] <= '0;
      outstanding <= '0;
      inflight    <= '0;
      RndErrxSO   <= 1'b0;
    end else begin
      running     <= 1'b1;
      sbox_hold   <= sbox_in;
      vld_pipe[0] <= accept;
      tag_pipe[0] <= InTagxDI;
      for (int i = 1; i < SBOX_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
      outstanding <= outstanding + CW'(accept) - CW'(pop);
      inflight    <= inflight + CW'(accept) - CW'(push);
      // The DOM gadgets consume randomness every cycle, stalled or not.
      if (!RndValidxSI && (inflight != '0)) RndErrxSO <= 1'b1;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    aes_sbox #(
      .SHARES   (SHARES),
      .SBOX_LAT (SBOX_LAT)
    ) u_sbox (
      .ClkxCI (ClkxCI),
      .RstxBI (RstxBI),
      .XxDI   (sbox_in[l*SHARES*8 +: SHARES*8]),
      .ZxDI   (RandomZxDI[l*RZ +: RZ]),
      .BtxDI  (RandomBxDI[l*RB +: RB]),
      .QxDO   (sbox_out[l*SHARES*8 +: SHARES*8])
    );
  end

  always_comb begin
    push_data = sbox_out;
`ifdef SBOX_AFFINE_EN
    // AES affine constant folded into share 0 only, so the sharing stays valid.
    for (int l = 0; l < LANES; l++)
      push_data[l*SHARES*8 +: 8] = sbox_out[l*SHARES*8 +: 8] ^ 8'h63;
`endif
  end

  sbox_stream_fifo #(
    .W     (DW + TAG_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (ClkxCI),
    .rst_n (RstxBI),
    .push  (push),
    .wdata ({push_data, tag_pipe[SBOX_LAT-1]}),
    .pop   (pop),
    .head  ({OutDataxDO, OutTagxDO}),
    .cnt   (fifo_cnt)
  );

endmodule

// File: tb/tb_masked_sbox_stream.sv
`timescale 1ns/1ps
module tb_masked_sbox_stream;
  localparam int SHARES   = 2;
  localparam int LANES    = 4;
  localparam int SBOX_LAT = 4;
  localparam int TAG_W    = 4;
  localparam int DEPTH    = SBOX_LAT + 2;
  localparam int DW       = 8 * SHARES * LANES;
  localparam int VW       = 8 * LANES;
  localparam int RZW      = LANES * 11 * SHARES * (SHARES - 1);
  localparam int RBW      = LANES * 18 * 1;
  localparam int EW       = TAG_W + VW;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_data;
  logic [TAG_W-1:0]  in_tag;
  logic              rnd_valid;
  logic [RZW-1:0]    rnd_z;
  logic [RBW-1:0]    rnd_b;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              rnd_err;

  int n_cmp;
  int n_fail;
  logic [EW-1:0] exp_q[$];

  masked_sbox_stream #(
    .SHARES(SHARES), .LANES(LANES), .SBOX_LAT(SBOX_LAT), .TAG_W(TAG_W)
  ) dut (
    .ClkxCI(clk), .RstxBI(rst_n),
    .InValidxSI(in_valid), .InReadyxSO(in_ready), .InDataxDI(in_data), .InTagxDI(in_tag),
    .RndValidxSI(rnd_valid), .RandomZxDI(rnd_z), .RandomBxDI(rnd_b),
    .OutValidxSO(out_valid), .OutReadyxSI(out_ready), .OutDataxDO(out_data), .OutTagxDO(out_tag),
    .RndErrxSO(rnd_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    logic hi;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      hi = aa[7];
      aa = aa << 1;
      if (hi) aa = aa ^ 8'h1b;
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Full AES SubBytes: brute-force inverse, then the bitwise affine map.
  function automatic logic [7:0] ref_sbox(input logic [7:0] x);
    logic [7:0] inv, b, c;
    inv = 8'h00;
    if (x != 8'h00)
      for (int y = 1; y < 256; y++)
        if (ref_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
    c = 8'h63;
    for (int i = 0; i < 8; i++)
      b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return b;
  endfunction

  function automatic logic [VW-1:0] unmask(input logic [DW-1:0] d);
    logic [VW-1:0] v;
    v = '0;
    for (int l = 0; l < LANES; l++)
      for (int s = 0; s < SHARES; s++)
        v[l*8 +: 8] = v[l*8 +: 8] ^ d[(l*SHARES+s)*8 +: 8];
    return v;
  endfunction

  function automatic logic [VW-1:0] expected_lanes(input logic [DW-1:0] d);
    logic [VW-1:0] x, y;
    x = unmask(d);
    for (int l = 0; l < LANES; l++) begin
      y[l*8 +: 8] = ref_sbox(x[l*8 +: 8]);
`ifndef SBOX_AFFINE_EN
      y[l*8 +: 8] = y[l*8 +: 8] ^ 8'h63;
`endif
    end
    return y;
  endfunction

  // ---------------- drivers ----------------
  task automatic make_data(input logic [VW-1:0] vals, output logic [DW-1:0] d);
    logic [7:0] m;
    for (int l = 0; l < LANES; l++) begin
      m = 8'($urandom_range(0, 255));
      d[(l*SHARES)*8 +: 8]   = vals[l*8 +: 8] ^ m;
      d[(l*SHARES+1)*8 +: 8] = m;
    end
  endtask

  function automatic logic [VW-1:0] rand_vals();
    logic [VW-1:0] v;
    for (int l = 0; l < LANES; l++) v[l*8 +: 8] = 8'($urandom_range(0, 255));
    return v;
  endfunction

  // One clock: drive at posedge+1, record accepts into the scoreboard,
  // sample and score the output beat at the following negedge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic [TAG_W-1:0] t,
                      input logic rv, input logic ordy, output logic acc, output logic got,
                      output logic [VW-1:0] gval, output logic [TAG_W-1:0] gtag);
    logic [EW-1:0] exp_e, obs_e;
    @(posedge clk); #1;
    in_valid = v; in_data = d; in_tag = t; rnd_valid = rv; out_ready = ordy;
    for (int i = 0; i < RZW; i++) rnd_z[i] = 1'($urandom_range(0, 1));
    for (int i = 0; i < RBW; i++) rnd_b[i] = 1'($urandom_range(0, 1));
    acc = v && in_ready && rv;
    if (acc) exp_q.push_back({t, expected_lanes(d)});
    @(negedge clk);
    got  = out_valid && out_ready;
    gval = unmask(out_data);
    gtag = out_tag;
    if (got) begin
      n_cmp++;
      obs_e = {gtag, gval};
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_unexpected: got %h, required no output beat", obs_e);
      end else begin
        exp_e = exp_q.pop_front();
        if (obs_e !== exp_e) begin
          n_fail++;
          $display("FAIL scoreboard_beat: got %h, required %h", obs_e, exp_e);
        end
      end
    end
  endtask

  task automatic drain(output int outs);
    logic acc, got;
    logic [VW-1:0] gv;
    logic [TAG_W-1:0] gt;
    outs = 0;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      step(1'b0, '0, '0, 1'b1, 1'b1, acc, got, gv, gt);
      if (got) outs++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_tag = '0;
    rnd_valid = 1'b1; rnd_z = '0; rnd_b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_low: got %b, required 0", in_ready); end
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    n_cmp++;
    if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h, required 0", out_data); end
    n_cmp++;
    if (out_tag !== '0) begin n_fail++; $display("FAIL reset_out_tag: got %h, required 0", out_tag); end
    n_cmp++;
    if (rnd_err !== 1'b0) begin n_fail++; $display("FAIL reset_rnd_err: got %b, required 0", rnd_err); end
  endtask

  task automatic test_affine_zero();
    logic [DW-1:0] d;
    logic acc, got;
    logic [VW-1:0] gv;
    logic [TAG_W-1:0] gt;
    logic [7:0] want;
    int lat;
    make_data(rand_vals(), d);
    d[15:0] = 16'hA5A5;
    step(1'b1, d, 4'h3, 1'b1, 1'b1, acc, got, gv, gt);
    n_cmp++;
    if (acc !== 1'b1) begin n_fail++; $display("FAIL affine_accept: got %b, required 1", acc); end
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      lat++;
      step(1'b0, '0, '0, 1'b1, 1'b1, acc, got, gv, gt);
    end
    n_cmp++;
    if (lat != SBOX_LAT + 1) begin n_fail++; $display("FAIL latency: got %0d cycles, required %0d", lat, SBOX_LAT + 1); end
`ifdef SBOX_AFFINE_EN
    want = 8'h63;
`else
    want = 8'h00;
`endif
    n_cmp++;
    if (gv[7:0] !== want) begin n_fail++; $display("FAIL lane0_zero: got %h, required %h", gv[7:0], want); end
  endtask

  task automatic test_known_values();
    logic [DW-1:0] d;
    logic [VW-1:0] vals;
    logic acc, got;
    logic [VW-1:0] gv;
    logic [TAG_W-1:0] gt;
    logic [7:0] w53, wff;
    int n;
    vals = rand_vals();
    vals[15:8]  = 8'h53;
    vals[23:16] = 8'hFF;
    make_data(vals, d);
    step(1'b1, d, 4'hA, 1'b1, 1'b1, acc, got, gv, gt);
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      n++;
      step(1'b0, '0, '0, 1'b1, 1'b1, acc, got, gv, gt);
    end
`ifdef SBOX_AFFINE_EN
    w53 = 8'hED; wff = 8'h16;
`else
    w53 = 8'h8E; wff = 8'h75;
`endif
    n_cmp++;
    if (gt !== 4'hA) begin n_fail++; $display("FAIL known_tag: got %h, required a", gt); end
    n_cmp++;
    if (gv[15:8] !== w53) begin n_fail++; $display("FAIL known_53: got %h, required %h", gv[15:8], w53); end
    n_cmp++;
    if (gv[23:16] !== wff) begin n_fail++; $display("FAIL known_ff: got %h, required %h", gv[23:16], wff); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d;
    logic acc, got;
    logic [VW-1:0] gv;
    logic [TAG_W-1:0] gt;
    int drops, outs, cyc, first_out, last_out, more;
    drops = 0; outs = 0; cyc = 0; first_out = -1; last_out = -1;
    for (int i = 0; i < 100; i++) begin
      make_data(rand_vals(), d);
      step(1'b1, d, TAG_W'(i), 1'b1, 1'b1, acc, got, gv, gt);
      if (!acc) drops++;
      if (got) begin outs++; if (first_out < 0) first_out = cyc; last_out = cyc; end
      cyc++;
    end
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) begin
      step(1'b0, '0, '0, 1'b1, 1'b1, acc, got, gv, gt);
      if (got) begin outs++; last_out = cyc; end
      cyc++;
    end
    more = 0;
    n_cmp++;
    if (drops != 0) begin n_fail++; $display("FAIL b2b_in_ready_drops: got %0d, required 0", drops); end
    n_cmp++;
    if (outs != 100) begin n_fail++; $display("FAIL b2b_out_count: got %0d, required 100", outs); end
    n_cmp++;
    if (last_out - first_out != 99) begin
      n_fail++; $display("FAIL b2b_throughput: got span %0d, required 99", last_out - first_out);
    end
    drain(more);
    n_cmp++;
    if (more != 0) begin n_fail++; $display("FAIL b2b_leftover: got %0d, required 0", more); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d;
    logic acc, got;
    logic [VW-1:0] gv;
    logic [TAG_W-1:0] gt;
    int accepted, outs;
    accepted = 0;
    for (int i = 0; i < 14; i++) begin
      make_data(rand_vals(), d);
      step(1'b1, d, TAG_W'(i + 5), 1'b1, 1'b0, acc, got, gv, gt);
      if (acc) accepted++;
    end
    n_cmp++;
    if (accepted != DEPTH) begin n_fail++; $display("FAIL bp_accepted: got %0d, required %0d", accepted, DEPTH); end
    n_cmp++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b, required 0", in_ready); end
    drain(outs);
    n_cmp++;
    if (outs != DEPTH) begin n_fail++; $display("FAIL bp_drained: got %0d, required %0d", outs, DEPTH); end
  endtask

  task automatic test_rnd_guard();
    logic [DW-1:0] d;
    logic acc, got;
    logic [VW-1:0] gv;
    logic [TAG_W-1:0] gt;
    int accepted, outs;
    accepted = 0;
    make_data(rand_vals(), d);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, d, 4'h1, 1'b0, 1'b1, acc, got, gv, gt);
      if (acc) accepted++;
    end
    n_cmp++;
    if (accepted != 0) begin n_fail++; $display("FAIL rnd_no_accept: got %0d, required 0", accepted); end
    n_cmp++;
    if (rnd_err !== 1'b0) begin n_fail++; $display("FAIL rnd_err_idle: got %b, required 0", rnd_err); end
    step(1'b1, d, 4'h5, 1'b1, 1'b1, acc, got, gv, gt);
    step(1'b0, '0, '0, 1'b1, 1'b1, acc, got, gv, gt);
    step(1'b0, '0, '0, 1'b0, 1'b1, acc, got, gv, gt);
    step(1'b0, '0, '0, 1'b1, 1'b1, acc, got, gv, gt);
    n_cmp++;
    if (rnd_err !== 1'b1) begin n_fail++; $display("FAIL rnd_err_set: got %b, required 1", rnd_err); end
    drain(outs);
    n_cmp++;
    if (outs != 1) begin n_fail++; $display("FAIL rnd_beat_emerged: got %0d, required 1", outs); end
    n_cmp++;
    if (rnd_err !== 1'b1) begin n_fail++; $display("FAIL rnd_err_sticky: got %b, required 1", rnd_err); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d;
    logic acc, got;
    logic [VW-1:0] gv;
    logic [TAG_W-1:0] gt;
    int seen;
    for (int i = 0; i < 3; i++) begin
      make_data(rand_vals(), d);
      step(1'b1, d, TAG_W'(i), 1'b1, 1'b1, acc, got, gv, gt);
    end
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, '0, '0, 1'b1, 1'b1, acc, got, gv, gt);
      if (out_valid) seen++;
    end
    n_cmp++;
    if (seen != 0) begin n_fail++; $display("FAIL mid_reset_outputs: got %0d, required 0", seen); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_in_ready: got %b, required 1", in_ready); end
    n_cmp++;
    if (rnd_err !== 1'b0) begin n_fail++; $display("FAIL mid_reset_rnd_err: got %b, required 0", rnd_err); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_affine_zero();
    test_known_values();
    test_back_to_back();
    test_backpressure();
    test_rnd_guard();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL final_queue: got %0d pending, required 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
